intensity_calc: RTL and testbench
=================================

# intensity_calc

Computes the Avellaneda–Stoikov order-arrival intensities λ_bid = A·exp(−k·δ_bid) and λ_ask = A·exp(−k·δ_ask) in q32.32 fixed point. It sits directly upstream and downstream of the exponential LUT. It forms and clamps the LUT argument, drives the LUT input, captures the LUT output one cycle later, and scales the result by A. The bid and ask LUT accesses are time-multiplexed through one external LUT instance. The quote-generation stage consumes the results over a valid/ready handshake.

## Interface
- `LUT_MIN`, default 64'hFFFF_FFFF_0000_0000, lower clamp of LUT argument (−1.0 q32.32)
- `LUT_MAX`, default 64'h0000_0001_0000_0000, upper clamp of LUT argument (+1.0 q32.32)
- `i_clk`  in  1  clock; single clock domain
- `i_rst_n`  in  1  reset; synchronous, active-low
- `i_valid`  in  1  request valid
- `o_ready`  out  1  block can accept a request (high only in IDLE)
- `i_a`, `i_k`, `i_delta_bid`, `i_delta_ask`  in  64 each  signed q32.32 operands
- `o_exp_arg`  out  64  signed q32.32 argument to the exp LUT (registered)
- `i_exp_value`  in  64  q32.32 LUT result (combinational from `o_exp_arg`)
- `o_valid`  out  1  results valid
- `i_ready`  in  1  consumer accepts results
- `o_lambda_bid`, `o_lambda_ask`  out  64 each  signed q32.32 intensities
- `o_clamp_bid`, `o_clamp_ask`  out  1 each  the argument for that side was clamped

## Operation
- FSM states: IDLE, ARG_BID, LUT_BID, ARG_ASK, LUT_ASK, MUL, DONE.
- **IDLE:** `o_ready`=1. On `i_valid`&&`o_ready`, latch all four operands and go to ARG_BID. Inputs are ignored at all other times.
- **ARG_BID / ARG_ASK:**
  - p = k·δ is a signed 128-bit product (q64.64). The argument is −p[95:32].
  - Saturation: if p[127:95] is not all-equal, or the negated value is outside [LUT_MIN, LUT_MAX], clamp to the nearer limit and set that side's clamp flag.
  - Register the argument into `o_exp_arg`, then go to LUT_BID / LUT_ASK.
- **LUT_BID / LUT_ASK:** `o_exp_arg` is held stable. At the end of the cycle, capture `i_exp_value` into exp_bid / exp_ask. LUT_BID goes to ARG_ASK; LUT_ASK goes to MUL.
- **MUL:**
  - λ = A·exp is a signed 128-bit product; the result is bits [95:32], saturated to 64'h7FFF…FFFF / 64'h8000…0000 on overflow.
  - Register both λ outputs, set `o_valid`, go to DONE.
- **DONE:** hold all outputs stable until `i_ready`. On `o_valid`&&`i_ready`, clear `o_valid` and go to IDLE. `o_ready` rises the following cycle; there is no same-cycle re-accept.
- Clamp flags update in ARG states and are valid together with `o_valid`.

## Timing
- Reset (`i_rst_n`=0 at a rising edge) puts the block in IDLE with:
  - `o_ready`=1 after reset release
  - `o_valid`=0
  - `o_exp_arg`=0, `o_lambda_*`=0, `o_clamp_*`=0
- Reset mid-operation aborts the transaction with no output.
- Latency: the accept edge is edge 0, and `o_valid` is high after edge 5.
  - Throughput is one request per 7 cycles with `i_ready` tied high.
- The LUT path is combinational. `i_exp_value` is sampled exactly one cycle after the `o_exp_arg` update.
- `o_exp_arg` retains its last value outside the ARG/LUT states.
- Back-pressure: the block stays in DONE indefinitely; outputs must not change while `o_valid`=1 && `i_ready`=0.
- `i_valid` is not required to be held. A request is taken only on the handshake edge.

## Structure
- Shared package `hft_pkg`:
  - `q32_32_t` (logic signed [63:0])
  - constants Q_ONE = 64'h1_0000_0000, Q_MAX, Q_MIN
  - FSM state enum `ic_state_t`
- One natural sub-module is `q_mul_sat`: signed q32.32 × q32.32 → q32.32 with saturation and an overflow flag. It is instantiated for k·δ (shared between bid and ask) and for A·exp.
- The exp LUT is instantiated by the parent, not inside this block.

## Test plan
- **Nominal:** A=2.0, k=1.0, δ_bid=0.5, δ_ask=0.25; bench LUT model returns 0x0000_0000_8000_0000 (0.5).
  - `o_exp_arg` = 0xFFFF_FFFF_8000_0000, then 0xFFFF_FFFF_C000_0000.
  - λ_bid = λ_ask = 0x1_0000_0000; clamps = 0; `o_valid` after edge 5.
- **Clamp low:** k=4.0, δ_bid=1.0 → `o_exp_arg` = LUT_MIN, `o_clamp_bid`=1.
- **Clamp high:** k=1.0, δ_ask=−3.0 → arg = LUT_MAX, `o_clamp_ask`=1.
- **Product overflow:** A=0x7FFF_FFFF_0000_0000, exp=2.0 → λ = 0x7FFF_FFFF_FFFF_FFFF.
- **Back-pressure:** hold `i_ready`=0 for 10 cycles in DONE → outputs stable, `o_ready`=0, and a new `i_valid` is ignored. After the release handshake, `o_ready`=1 on the next cycle.
- **Reset mid-op:** assert `i_rst_n`=0 during LUT_ASK → next cycle IDLE, `o_valid`=0, all outputs 0. A fresh request then completes normally.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared fixed-point types, constants and FSM encoding for the quoting pipeline.
// All arithmetic values are signed q32.32 held in 64 bits.
package hft_pkg;

  typedef logic signed [63:0] q32_32_t;

  localparam q32_32_t Q_ONE = 64'h0000_0001_0000_0000;
  localparam q32_32_t Q_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam q32_32_t Q_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARG_BID = 3'd1,
    S_LUT_BID = 3'd2,
    S_ARG_ASK = 3'd3,
    S_LUT_ASK = 3'd4,
    S_MUL     = 3'd5,
    S_DONE    = 3'd6
  } ic_state_t;

endpackage

// File: rtl/q_mul_sat.sv
// Signed q32.32 x q32.32 -> q32.32 multiply with saturation.
// overflow is set whenever the q64.64 product does not fit the q32.32 result.
module q_mul_sat
  import hft_pkg::*;
(
  input  q32_32_t a,
  input  q32_32_t b,
  output q32_32_t result,
  output logic    overflow
);

  logic [127:0] a_ext;
  logic [127:0] b_ext;
  logic [127:0] prod;
  logic         unused_lsbs;

  // Sign-extended unsigned multiply gives the exact two's complement low 128 bits.
  assign a_ext = {{64{a[63]}}, a};
  assign b_ext = {{64{b[63]}}, b};
  assign prod  = a_ext * b_ext;

  // The result fits only when bits 127..95 are all copies of the sign.
  assign overflow = !((&prod[127:95]) || (~|prod[127:95]));

  always_comb begin
    result = prod[95:32];
    if (overflow) begin
      result = prod[127] ? Q_MIN : Q_MAX;
    end
  end

  assign unused_lsbs = ^prod[31:0];

endmodule

// File: rtl/intensity_calc.sv
// Avellaneda-Stoikov intensities lambda = A*exp(-k*delta) for bid and ask,
// sharing one external exp LUT and one k*delta multiplier across the two sides.
module intensity_calc
  import hft_pkg::*;
#(
  parameter q32_32_t LUT_MIN = 64'hFFFF_FFFF_0000_0000,
  parameter q32_32_t LUT_MAX = 64'h0000_0001_0000_0000
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_valid,
  output logic      o_ready,
  input  q32_32_t   i_a,
  input  q32_32_t   i_k,
  input  q32_32_t   i_delta_bid,
  input  q32_32_t   i_delta_ask,
  output q32_32_t   o_exp_arg,
  input  q32_32_t   i_exp_value,
  output logic      o_valid,
  input  logic      i_ready,
  output q32_32_t   o_lambda_bid,
  output q32_32_t   o_lambda_ask,
  output logic      o_clamp_bid,
  output logic      o_clamp_ask,
  output ic_state_t o_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. o_ready is high only in IDLE; o_valid, once raised, holds the
  // results stable until the consumer takes them with i_ready.

  ic_state_t state;

  q32_32_t a_r;
  q32_32_t k_r;
  q32_32_t delta_bid_r;
  q32_32_t delta_ask_r;
  q32_32_t exp_bid;
  q32_32_t exp_ask;

  q32_32_t             delta_sel;
  q32_32_t             kd_result;
  logic                kd_ovf;
  logic signed [64:0]  neg_arg;
  logic signed [64:0]  lut_min_ext;
  logic signed [64:0]  lut_max_ext;
  q32_32_t             arg_next;
  logic                clamp_next;

  q32_32_t lam_bid;
  q32_32_t lam_ask;
  logic    lam_bid_ovf;
  logic    lam_ask_ovf;
  logic    unused_lam_ovf;

  assign delta_sel = (state == S_ARG_ASK) ? delta_ask_r : delta_bid_r;

  q_mul_sat u_kd (
    .a        (k_r),
    .b        (delta_sel),
    .result   (kd_result),
    .overflow (kd_ovf)
  );

  assign lut_min_ext = {LUT_MIN[63], LUT_MIN};
  assign lut_max_ext = {LUT_MAX[63], LUT_MAX};

  // Negate in 65 bits so that negating the most negative product cannot wrap.
  always_comb begin
    arg_next   = '0;
    clamp_next = 1'b0;
    neg_arg    = -{kd_result[63], kd_result};
    if (kd_ovf) begin
      clamp_next = 1'b1;
      arg_next   = kd_result[63] ? LUT_MAX : LUT_MIN;
    end else if (neg_arg < lut_min_ext) begin
      clamp_next = 1'b1;
      arg_next   = LUT_MIN;
    end else if (neg_arg > lut_max_ext) begin
      clamp_next = 1'b1;
      arg_next   = LUT_MAX;
    end else begin
      arg_next   = neg_arg[63:0];
    end
  end

  q_mul_sat u_lam_bid (
    .a        (a_r),
    .b        (exp_bid),
    .result   (lam_bid),
    .overflow (lam_bid_ovf)
  );

  q_mul_sat u_lam_ask (
    .a        (a_r),
    .b        (exp_ask),
    .result   (lam_ask),
    .overflow (lam_ask_ovf)
  );

  assign unused_lam_ovf = lam_bid_ovf ^ lam_ask_ovf;

  assign o_ready = (state == S_IDLE);
  assign o_state = state;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      a_r          <= '0;
      k_r          <= '0;
      delta_bid_r  <= '0;
      delta_ask_r  <= '0;
      exp_bid      <= '0;
      exp_ask      <= '0;
      o_exp_arg    <= '0;
      o_valid      <= 1'b0;
      o_lambda_bid <= '0;
      o_lambda_ask <= '0;
      o_clamp_bid  <= 1'b0;
      o_clamp_ask  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            a_r         <= i_a;
            k_r         <= i_k;
            delta_bid_r <= i_delta_bid;
            delta_ask_r <= i_delta_ask;
            state       <= S_ARG_BID;
          end
        end
        S_ARG_BID: begin
          o_exp_arg   <= arg_next;
          o_clamp_bid <= clamp_next;
          state       <= S_LUT_BID;
        end
        S_LUT_BID: begin
          exp_bid <= i_exp_value;
          state   <= S_ARG_ASK;
        end
        S_ARG_ASK: begin
          o_exp_arg   <= arg_next;
          o_clamp_ask <= clamp_next;
          state       <= S_LUT_ASK;
        end
        S_LUT_ASK: begin
          exp_ask <= i_exp_value;
          state   <= S_MUL;
        end
        S_MUL: begin
          o_lambda_bid <= lam_bid;
          o_lambda_ask <= lam_ask;
          o_valid      <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intensity_calc.sv
// Directed bench for intensity_calc: vector table with hand-computed results,
// plus back-pressure and mid-operation reset sequences.
module tb_intensity_calc;
  import hft_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      i_valid;
  logic      o_ready;
  q32_32_t   i_a, i_k, i_delta_bid, i_delta_ask;
  q32_32_t   o_exp_arg;
  q32_32_t   exp_value;
  logic      o_valid;
  logic      i_ready;
  q32_32_t   o_lambda_bid, o_lambda_ask;
  logic      o_clamp_bid, o_clamp_ask;
  ic_state_t o_state;

  logic    lut_lin;
  q32_32_t lut_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string   name;
    q32_32_t a, k, db, da;
    logic    lin;
    q32_32_t lc;
    q32_32_t arg_b, arg_a, lam_b, lam_a;
    logic    cb, ca;
  } vec_t;

  vec_t vecs[7];

  intensity_calc dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_a          (i_a),
    .i_k          (i_k),
    .i_delta_bid  (i_delta_bid),
    .i_delta_ask  (i_delta_ask),
    .o_exp_arg    (o_exp_arg),
    .i_exp_value  (exp_value),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_lambda_bid (o_lambda_bid),
    .o_lambda_ask (o_lambda_ask),
    .o_clamp_bid  (o_clamp_bid),
    .o_clamp_ask  (o_clamp_ask),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  // LUT model: either a fixed value or the linear form 1 + x, so that a
  // capture on the wrong cycle picks up the other side's argument.
  always_comb begin
    exp_value = lut_lin ? (o_exp_arg + Q_ONE) : lut_c;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    i_a         = {$urandom(), $urandom()};
    i_k         = {$urandom(), $urandom()};
    i_delta_bid = {$urandom(), $urandom()};
    i_delta_ask = {$urandom(), $urandom()};
  endtask

  // Waits (bounded) for o_ready, presents v and completes the accept edge.
  task automatic accept(input vec_t v);
    int n;
    n = 0;
    while (!o_ready && n < 20) begin
      tick();
      n++;
    end
    chk({v.name, "_ready_wait"}, 64'(o_ready), 64'(1));
    lut_lin     = v.lin;
    lut_c       = v.lc;
    i_a         = v.a;
    i_k         = v.k;
    i_delta_bid = v.db;
    i_delta_ask = v.da;
    i_valid     = 1'b1;
    tick();
    i_valid = 1'b0;
    scramble_inputs();
    chk({v.name, "_busy"}, 64'(o_ready), 64'(0));
  endtask

  task automatic run_to_done(input vec_t v);
    accept(v);
    tick();
    chk({v.name, "_arg_bid"}, o_exp_arg, v.arg_b);
    tick();
    tick();
    chk({v.name, "_arg_ask"}, o_exp_arg, v.arg_a);
    tick();
    chk({v.name, "_valid_e4"}, 64'(o_valid), 64'(0));
    tick();
    chk({v.name, "_valid_e5"}, 64'(o_valid), 64'(1));
    chk({v.name, "_lam_bid"}, o_lambda_bid, v.lam_b);
    chk({v.name, "_lam_ask"}, o_lambda_ask, v.lam_a);
    chk({v.name, "_clamp_bid"}, 64'(o_clamp_bid), 64'(v.cb));
    chk({v.name, "_clamp_ask"}, 64'(o_clamp_ask), 64'(v.ca));
    chk({v.name, "_arg_hold"}, o_exp_arg, v.arg_a);
  endtask

  task automatic release_done(input string name);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({name, "_valid_clr"}, 64'(o_valid), 64'(0));
    chk({name, "_ready_back"}, 64'(o_ready), 64'(1));
  endtask

  initial begin
    vecs[0] = '{"nominal", 64'h2_0000_0000, 64'h1_0000_0000, 64'h0_8000_0000, 64'h0_4000_0000,
                1'b0, 64'h0_8000_0000,
                64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_C000_0000,
                64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{"clamp_low", 64'h1_0000_0000, 64'h4_0000_0000, 64'h1_0000_0000, 64'h0,
                1'b1, 64'h0,
                64'hFFFF_FFFF_0000_0000, 64'h0,
                64'h0, 64'h1_0000_0000, 1'b1, 1'b0};
    vecs[2] = '{"clamp_high", 64'h1_0000_0000, 64'h1_0000_0000, 64'h0_4000_0000, 64'hFFFF_FFFD_0000_0000,
                1'b1, 64'h0,
                64'hFFFF_FFFF_C000_0000, 64'h1_0000_0000,
                64'h0_C000_0000, 64'h2_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{"ovf_pos", 64'h7FFF_FFFF_0000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000,
                1'b1, 64'h0,
                64'h1_0000_0000, 64'h1_0000_0000,
                64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[4] = '{"ovf_neg", 64'h8000_0000_0000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000,
                1'b1, 64'h0,
                64'h1_0000_0000, 64'h1_0000_0000,
                64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
    vecs[5] = '{"kd_ovf", 64'h1_0000_0000, 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_0000_0000, 64'h8000_0000_0000_0000,
                1'b1, 64'h0,
                64'hFFFF_FFFF_0000_0000, 64'h1_0000_0000,
                64'h0, 64'h2_0000_0000, 1'b1, 1'b1};
    vecs[6] = '{"fraction", 64'h3_0000_0000, 64'h0_8000_0000, 64'h1_0000_0000, 64'h0_8000_0000,
                1'b1, 64'h0,
                64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_C000_0000,
                64'h1_8000_0000, 64'h2_4000_0000, 1'b0, 1'b0};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    lut_lin = 1'b0;
    lut_c   = '0;
    scramble_inputs();
    repeat (3) tick();
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_exp_arg", o_exp_arg, 64'h0);
    chk("rst_lam_bid", o_lambda_bid, 64'h0);
    chk("rst_lam_ask", o_lambda_ask, 64'h0);
    chk("rst_clamps", 64'({o_clamp_bid, o_clamp_ask}), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(o_ready), 64'(1));

    foreach (vecs[i]) begin
      run_to_done(vecs[i]);
      release_done(vecs[i].name);
    end

    // Back-pressure: results must hold and new requests must be ignored.
    run_to_done(vecs[2]);
    for (int c = 0; c < 10; c++) begin
      i_valid = 1'b1;
      scramble_inputs();
      tick();
      chk("bp_valid", 64'(o_valid), 64'(1));
      chk("bp_ready", 64'(o_ready), 64'(0));
      chk("bp_state", 64'(o_state), 64'(S_DONE));
      chk("bp_lam_bid", o_lambda_bid, vecs[2].lam_b);
      chk("bp_lam_ask", o_lambda_ask, vecs[2].lam_a);
      chk("bp_clamps", 64'({o_clamp_bid, o_clamp_ask}), 64'({vecs[2].cb, vecs[2].ca}));
      chk("bp_exp_arg", o_exp_arg, vecs[2].arg_a);
    end
    release_done("bp");
    i_valid = 1'b0;
    chk("bp_no_reaccept", 64'(o_state), 64'(S_IDLE));
    tick();
    chk("bp_idle_hold", 64'(o_ready), 64'(1));

    // Reset during LUT_ASK aborts the transaction and clears every output.
    accept(vecs[6]);
    repeat (3) tick();
    chk("mid_state", 64'(o_state), 64'(S_LUT_ASK));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_state_idle", 64'(o_state), 64'(S_IDLE));
    chk("mid_valid", 64'(o_valid), 64'(0));
    chk("mid_ready", 64'(o_ready), 64'(1));
    chk("mid_exp_arg", o_exp_arg, 64'h0);
    chk("mid_lam_bid", o_lambda_bid, 64'h0);
    chk("mid_lam_ask", o_lambda_ask, 64'h0);
    chk("mid_clamps", 64'({o_clamp_bid, o_clamp_ask}), 64'(0));
    repeat (3) begin
      tick();
      chk("mid_no_output", 64'(o_valid), 64'(0));
    end
    run_to_done(vecs[0]);
    release_done("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
